// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, writeback request payload, arbiter states.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        RUN   = 1'b0,
        FORCE = 1'b1
    } arb_state_t;

endpackage : core_pkg

// File: rtl/wb_skid_fifo.sv
// In-order buffer for long-latency results; exposes per-slot valid/rd for hazard decode.
module wb_skid_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 5,
    parameter int unsigned XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [AW-1:0]                push_rd,
    input  logic [XLEN-1:0]              push_data,
    input  logic                         pop,
    output logic [AW-1:0]                head_rd,
    output logic [XLEN-1:0]              head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][AW-1:0]     ent_rd
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][AW-1:0] rd_mem;
    logic [XLEN-1:0]          data_mem [DEPTH];
    logic [DEPTH-1:0]         vld;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    // Pointers, slot valid bits and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= CW'(count + 1'b1);
            end else if (pop && !push) begin
                count <= CW'(count - 1'b1);
            end
        end
    end

    // Payload storage; contents are qualified by vld so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign ent_valid = vld;
    assign ent_rd    = rd_mem;

endmodule : wb_skid_fifo

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline WB and buffered long-latency results.
module regfile_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = core_pkg::XLEN,
    parameter int unsigned AW         = core_pkg::AW,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid,
    input  logic [AW-1:0]                wb_rd,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         lu_valid,
    output logic                         lu_ready,
    input  logic [AW-1:0]                lu_rd,
    input  logic [XLEN-1:0]              lu_data,
    output logic                         pipe_stall,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_a3,
    output logic [XLEN-1:0]              rf_wd3,
    output logic [(2**AW)-1:0]           pend_mask,
    output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_t               state, state_nx;
    logic [SW-1:0]            starve_cnt, starve_nx;
    logic                     push, pop, fifo_empty;
    logic [AW-1:0]            head_rd;
    logic [XLEN-1:0]          head_data;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_rd;
    wb_req_t                  wr_sel;

    assign lu_ready   = (buf_count < ($clog2(DEPTH+1))'(DEPTH));
    assign push       = lu_valid && lu_ready;
    assign fifo_empty = (buf_count == '0);

    wb_skid_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (lu_rd),
        .push_data (lu_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (buf_count),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
        end
    end

    // Port selection, pop control and next-state; everything idle while in reset.
    always_comb begin
        state_nx   = state;
        starve_nx  = starve_cnt;
        pop        = 1'b0;
        pipe_stall = 1'b0;
        wr_sel     = '0;
        if (rst) begin
            unique case (state)
                RUN: begin
                    if (wb_valid) begin
                        wr_sel = '{valid: 1'b1, rd: wb_rd, data: wb_data};
                        if (!fifo_empty) begin
                            if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                                state_nx  = FORCE;
                                starve_nx = '0;
                            end else begin
                                starve_nx = SW'(starve_cnt + 1'b1);
                            end
                        end
                    end else if (!fifo_empty) begin
                        wr_sel    = '{valid: 1'b1, rd: head_rd, data: head_data};
                        pop       = 1'b1;
                        starve_nx = '0;
                    end
                end
                FORCE: begin
                    pipe_stall = 1'b1;
                    wr_sel     = '{valid: 1'b1, rd: head_rd, data: head_data};
                    pop        = 1'b1;
                    starve_nx  = '0;
                    state_nx   = RUN;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // x0 writes complete as normal but never touch the register file.
    assign rf_we  = wr_sel.valid && (wr_sel.rd != '0);
    assign rf_a3  = wr_sel.rd;
    assign rf_wd3 = wr_sel.data;

    // Destination registers still owned by buffered results.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_valid[i]) begin
                pend_mask[ent_rd[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed checks of the register-file write-port arbiter (DEPTH=2, STARVE_MAX=4).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [31:0] pend_mask;
    logic [1:0]  buf_count;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(
        .XLEN       (32),
        .AW         (5),
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_a3      (rf_a3),
        .rf_wd3     (rf_wd3),
        .pend_mask  (pend_mask),
        .buf_count  (buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks follow 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5A5A5;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h1;
        repeat (3) tick();
        settle();
        chk("rst_we",    64'(rf_we),      64'h0);
        chk("rst_ready", 64'(lu_ready),   64'h1);
        chk("rst_count", 64'(buf_count),  64'h0);
        chk("rst_stall", 64'(pipe_stall), 64'h0);
        chk("rst_pend",  64'(pend_mask),  64'h0);

        // Release reset: WB write appears in the same cycle.
        tick(); rst = 1'b1; lu_valid = 1'b0; settle();
        chk("rel_we", 64'(rf_we),  64'h1);
        chk("rel_a3", 64'(rf_a3),  64'h5);
        chk("rel_wd", 64'(rf_wd3), 64'hA5A5A5A5);

        // Idle drain of a single LU result.
        tick(); wb_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234; settle();
        chk("idle_push_we", 64'(rf_we), 64'h0);
        chk("idle_ready",   64'(lu_ready), 64'h1);
        tick(); lu_valid = 1'b0; settle();
        chk("idle_we",    64'(rf_we),     64'h1);
        chk("idle_a3",    64'(rf_a3),     64'h7);
        chk("idle_wd",    64'(rf_wd3),    64'h1234);
        chk("idle_count", 64'(buf_count), 64'h1);
        chk("idle_pend",  64'(pend_mask), 64'h80);
        tick(); settle();
        chk("idle_after_we",   64'(rf_we),     64'h0);
        chk("idle_after_pend", 64'(pend_mask), 64'h0);
        chk("idle_after_cnt",  64'(buf_count), 64'h0);

        // Starvation: continuous WB, one LU result forced in after four WB wins.
        tick(); wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hBEEF; settle();
        chk("stv_push_a3", 64'(rf_a3), 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick(); lu_valid = 1'b0; wb_rd = 5'(11 + i); wb_data = 32'(i); settle();
            chk("stv_wb_stall", 64'(pipe_stall), 64'h0);
            chk("stv_wb_a3",    64'(rf_a3),      64'(11 + i));
            chk("stv_wb_cnt",   64'(buf_count),  64'h1);
        end
        tick(); wb_rd = 5'd2; wb_data = 32'h22; settle();
        chk("stv_force_stall", 64'(pipe_stall), 64'h1);
        chk("stv_force_we",    64'(rf_we),      64'h1);
        chk("stv_force_a3",    64'(rf_a3),      64'hA);
        chk("stv_force_wd",    64'(rf_wd3),     64'hBEEF);
        tick(); settle();
        chk("stv_resume_stall", 64'(pipe_stall), 64'h0);
        chk("stv_resume_a3",    64'(rf_a3),      64'h2);
        chk("stv_resume_cnt",   64'(buf_count),  64'h0);

        // Backpressure: three LU offers against a busy WB stream.
        wb_rd = 5'd3; wb_data = 32'h33;
        tick(); lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'hA0; settle();
        chk("bp_a_ready", 64'(lu_ready), 64'h1);
        tick(); lu_rd = 5'd21; lu_data = 32'hA1; settle();
        chk("bp_b_ready", 64'(lu_ready),  64'h1);
        chk("bp_b_cnt",   64'(buf_count), 64'h1);
        tick(); lu_rd = 5'd22; lu_data = 32'hA2; settle();
        chk("bp_c_ready", 64'(lu_ready),  64'h0);
        chk("bp_c_cnt",   64'(buf_count), 64'h2);
        chk("bp_c_pend",  64'(pend_mask), 64'h00300000);
        tick(); settle();
        chk("bp_d_ready", 64'(lu_ready),   64'h0);
        chk("bp_d_stall", 64'(pipe_stall), 64'h0);
        tick(); settle();
        chk("bp_e_ready", 64'(lu_ready),   64'h0);
        chk("bp_e_stall", 64'(pipe_stall), 64'h0);
        tick(); settle();
        chk("bp_f_stall", 64'(pipe_stall), 64'h1);
        chk("bp_f_a3",    64'(rf_a3),      64'd20);
        chk("bp_f_wd",    64'(rf_wd3),     64'hA0);
        chk("bp_f_ready", 64'(lu_ready),   64'h0);
        tick(); settle();
        chk("bp_g_ready", 64'(lu_ready),   64'h1);
        chk("bp_g_stall", 64'(pipe_stall), 64'h0);
        chk("bp_g_cnt",   64'(buf_count),  64'h1);
        chk("bp_g_a3",    64'(rf_a3),      64'h3);
        tick(); lu_valid = 1'b0; wb_valid = 1'b0; settle();
        chk("bp_h_a3",  64'(rf_a3),     64'd21);
        chk("bp_h_wd",  64'(rf_wd3),    64'hA1);
        chk("bp_h_cnt", 64'(buf_count), 64'h2);
        tick(); settle();
        chk("bp_i_a3",  64'(rf_a3),     64'd22);
        chk("bp_i_wd",  64'(rf_wd3),    64'hA2);
        chk("bp_i_cnt", 64'(buf_count), 64'h1);
        tick(); settle();
        chk("bp_j_we",  64'(rf_we),     64'h0);
        chk("bp_j_cnt", 64'(buf_count), 64'h0);

        // x0 destinations on both paths.
        tick(); wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF; settle();
        chk("x0_wb_we", 64'(rf_we), 64'h0);
        tick(); wb_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h77; settle();
        chk("x0_push_we", 64'(rf_we), 64'h0);
        tick(); lu_valid = 1'b0; settle();
        chk("x0_lu_we",   64'(rf_we),     64'h0);
        chk("x0_lu_cnt",  64'(buf_count), 64'h1);
        chk("x0_lu_pend", 64'(pend_mask), 64'h0);
        tick(); settle();
        chk("x0_popped_cnt", 64'(buf_count), 64'h0);

        // Reset while two entries are buffered.
        tick(); wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC0;
        tick(); lu_rd = 5'd13; lu_data = 32'hC1;
        tick(); lu_valid = 1'b0; settle();
        chk("mr_full_cnt",  64'(buf_count), 64'h2);
        chk("mr_full_pend", 64'(pend_mask), 64'h00003000);
        tick(); rst = 1'b0; settle();
        chk("mr_cnt",   64'(buf_count), 64'h0);
        chk("mr_pend",  64'(pend_mask), 64'h0);
        chk("mr_we",    64'(rf_we),     64'h0);
        chk("mr_ready", 64'(lu_ready),  64'h1);
        tick(); rst = 1'b1; wb_valid = 1'b0; settle();
        chk("mr_rel_we",  64'(rf_we),     64'h0);
        chk("mr_rel_cnt", 64'(buf_count), 64'h0);
        tick(); settle();
        chk("mr_stale_we", 64'(rf_we), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the single-write-port register file in the pipelined core. It shares the one write port between the in-order pipeline writeback stage and a long-latency unit (divider/load miss path). Long-latency results are held in a small FIFO, and a starvation guard stalls the pipeline so that buffered results always drain. It sits between the WB stage, the long-latency unit and the register file's A3/WD3/WE3 inputs, and it exports a pending-register mask to the hazard unit.

## Interface
Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- DEPTH, 2, long-latency FIFO entries (≥1)
- STARVE_MAX, 4, consecutive lost arbitrations before a forced drain (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline writeback request this cycle
- wb_rd  in  AW  pipeline destination register
- wb_data  in  XLEN  pipeline result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept; transfer on lu_valid & lu_ready at the clock edge
- lu_rd  in  AW  long-latency destination register
- lu_data  in  XLEN  long-latency result
- pipe_stall  out  1  hold the WB stage; wb_valid is ignored while high
- rf_we  out  1  register-file write enable
- rf_a3  out  AW  register-file write address
- rf_wd3  out  XLEN  register-file write data
- pend_mask  out  2**AW  bit r is set when a valid FIFO entry targets rd=r (bit 0 is always 0)
- buf_count  out  clog2(DEPTH+1)  FIFO occupancy

## Operation
- FIFO: in-order. Push on lu_valid & lu_ready. lu_ready = (buf_count < DEPTH), with no full-pass-through.
- FSM states are RUN and FORCE.
- RUN, port selection in priority order:
  - wb_valid: write WB.
  - Else, FIFO non-empty: write head and pop.
  - Else: idle, rf_we=0.
- starve_cnt:
  - Increments in RUN when the FIFO is non-empty and WB wins.
  - Clears on any pop.
  - When it would reach STARVE_MAX, the next state is FORCE and starve_cnt clears.
- FORCE: pipe_stall=1. Write the FIFO head and pop, then return to RUN. The FIFO is always non-empty on entry.
- Writes with rd=0 drive rf_we=0 but still pop or complete normally.
- Push and pop in the same cycle leave buf_count unchanged. A push into an empty FIFO is not written in the same cycle.
- WAW ordering between WB and FIFO entries is guaranteed upstream by the hazard unit via pend_mask. This block does not reorder or squash.
- rf_we/rf_a3/rf_wd3/pipe_stall are combinational from state and inputs. FIFO, FSM and starve_cnt are registers.

## Timing
- WB path adds zero latency: rf_we asserts in the same cycle as wb_valid, and the register file updates at the next edge.
- LU path: an entry pushed at edge k is eligible from cycle k+1. Worst-case write is at cycle k+1 + DEPTH·(STARVE_MAX+1).
- pipe_stall is high for exactly one cycle per FORCE entry.
- Reset, asynchronous and mid-operation: FIFO flushed (buf_count=0, pend_mask=0), state RUN, starve_cnt=0. Outputs during and after reset: rf_we=0, pipe_stall=0, lu_ready=1. rf_a3 and rf_wd3 are don't-care while rf_we=0.
- Full FIFO with lu_valid: lu_ready=0 for that cycle, even if a pop happens; the offer is accepted in the next cycle.

## Structure
- Shared package core_pkg holds:
  - XLEN and AW constants.
  - wb_req_t struct (valid, rd, data).
  - arb_state_t enum (RUN, FORCE).
- Sub-module wb_skid_fifo: parameterised FIFO (DEPTH, payload rd+data) exposing push/pop, count, and per-entry valid/rd for the pend_mask decode.
- Top module holds the FSM, starvation counter and port mux.

## Test plan
- Reset: hold rst=0 with lu_valid=1 and wb_valid=1 → rf_we=0, lu_ready=1, buf_count=0. Release rst → a WB write to x5 with data 0xA5A5A5A5 appears the same cycle.
- Idle drain: push lu_rd=7, data 0x1234 with wb_valid=0 → rf_we=1, rf_a3=7 in the next cycle. pend_mask bit 7 is set for exactly one cycle.
- Starvation: hold wb_valid=1 continuously and push one LU result (STARVE_MAX=4) → four WB writes, then pipe_stall=1 for one cycle with the LU write, then WB resumes.
- Full/backpressure: with DEPTH=2, push 3 LU results while wb_valid=1 → lu_ready drops after the 2nd push. The 3rd is accepted only after a pop, and the write order is preserved.
- x0 handling: wb_rd=0 gives rf_we=0. An LU entry with rd=0 pops with rf_we=0, buf_count decrements, and pend_mask bit 0 stays 0.
- Reset mid-operation: FIFO holding 2 entries, assert rst for one cycle → buf_count=0, pend_mask=0, and no stale writes after release.
